// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: state encodings and frame geometry.
// Imported by the receiver and available to the transmitter / status logic.
package uart_rx_pkg;

  // Receiver FSM states; encodings are fixed so the status register and
  // any debug taps can decode them directly.
  typedef enum logic [1:0] {
    RX_IDLE   = 2'b00,
    RX_START  = 2'b01,
    RX_DATA   = 2'b11,
    RX_BREAK  = 2'b10
  } rx_state_t;

  // Frame: 1 start, DATA_BITS data (LSB first), 1 stop, no parity.
  localparam int DATA_BITS = 8;

  // Number of baud ticks per bit cell.
  localparam int OVERSAMPLE = 8;

  // Oversample count on which a bit cell is sampled (centre of the cell).
  localparam logic [2:0] MID_SAMPLE = 3'(OVERSAMPLE - 1);

  // Count reached in start detection when the start bit is confirmed.
  // Together with the idle-state sample this needs 1+4 low samples,
  // which places the confirmation near the middle of the start cell.
  localparam logic [2:0] START_CONFIRM = 3'd3;

  // Bit counter value at which the stop bit is being sampled.
  localparam logic [3:0] STOP_INDEX = 4'(DATA_BITS);

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: baud tick input, serial line, the status
// flag fed back from the status register, and the receive results.
interface uart_rx_if;

  logic       bclkx8;
  logic       rxd;
  logic       rdrf;
  logic [7:0] rdr;
  logic       setrdrf;
  logic       setoe;
  logic       setfe;

  // Driver side: baud generator, line and status register.
  modport master (
    output bclkx8,
    output rxd,
    output rdrf,
    input  rdr,
    input  setrdrf,
    input  setoe,
    input  setfe
  );

  // Receiver side.
  modport slave (
    input  bclkx8,
    input  rxd,
    input  rdrf,
    output rdr,
    output setrdrf,
    output setoe,
    output setfe
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Resets to 1 so an idle-high serial line does not look like a start bit
// while the flops fill after reset.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8x oversampled start detection, mid-cell data sampling,
// stop-bit check, and single-cycle status set pulses alongside the new byte.
module uart_rx
  import uart_rx_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  rx
);

  logic       rxd_s;
  logic       bclkd;
  logic       tick;

  rx_state_t  state;
  logic [7:0] rsr;
  logic [2:0] ct1;
  logic [3:0] ct2;

  logic [7:0] rdr_q;
  logic       setrdrf_q;
  logic       setoe_q;
  logic       setfe_q;

  uart_sync2 u_rxd_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx.rxd),
    .q   (rxd_s)
  );

  // Remember the previous baud clock level to find its rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclkd <= 1'b0;
    end else begin
      bclkd <= rx.bclkx8;
    end
  end

  assign tick = rx.bclkx8 & ~bclkd;

  // Receive FSM with shift register, counters and registered status pulses;
  // everything except pulse clearing advances only on baud ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      rsr       <= 8'h00;
      ct1       <= 3'd0;
      ct2       <= 4'd0;
      rdr_q     <= 8'h00;
      setrdrf_q <= 1'b0;
      setoe_q   <= 1'b0;
      setfe_q   <= 1'b0;
    end else begin
      setrdrf_q <= 1'b0;
      setoe_q   <= 1'b0;
      setfe_q   <= 1'b0;
      if (tick) begin
        case (state)
          RX_IDLE: begin
            if (!rxd_s) begin
              state <= RX_START;
              ct1   <= 3'd0;
            end
          end
          RX_START: begin
            if (rxd_s) begin
              state <= RX_IDLE;
              ct1   <= 3'd0;
            end else if (ct1 == START_CONFIRM) begin
              state <= RX_DATA;
              ct1   <= 3'd0;
            end else begin
              ct1 <= ct1 + 3'd1;
            end
          end
          RX_DATA: begin
            ct1 <= ct1 + 3'd1;
            if (ct1 == MID_SAMPLE) begin
              if (ct2 < STOP_INDEX) begin
                rsr <= {rxd_s, rsr[7:1]};
                ct2 <= ct2 + 4'd1;
              end else begin
                rdr_q     <= rsr;
                setrdrf_q <= 1'b1;
                setoe_q   <= rx.rdrf;
                setfe_q   <= ~rxd_s;
                ct1       <= 3'd0;
                ct2       <= 4'd0;
                state     <= rxd_s ? RX_IDLE : RX_BREAK;
              end
            end
          end
          RX_BREAK: begin
            if (rxd_s) begin
              state <= RX_IDLE;
            end
          end
          default: begin
            state <= RX_IDLE;
          end
        endcase
      end
    end
  end

  assign rx.rdr     = rdr_q;
  assign rx.setrdrf = setrdrf_q;
  assign rx.setoe   = setoe_q;
  assign rx.setfe   = setfe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: frames are driven with a programmable bit
// length in clk cycles against a baud x8 clock of 16 clk per tick.
module tb_uart_rx;
  import uart_rx_pkg::*;

  logic clk;
  logic rst;

  uart_rx_if rx ();

  uart_rx dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx)
  );

  int vectors;
  int miscompares;

  int rdrf_pulses;
  int oe_pulses;
  int fe_pulses;
  int stray_pulses;
  logic [7:0] last_rdr;

  localparam int BIT_CLKS = 128;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud x8 clock: toggles every 8 clk, so one tick every 16 clk.
  initial begin
    rx.bclkx8 = 1'b0;
    forever begin
      repeat (8) @(negedge clk);
      rx.bclkx8 = ~rx.bclkx8;
    end
  end

  // Pulse monitor, sampled on the falling edge away from the DUT update.
  initial begin
    rdrf_pulses  = 0;
    oe_pulses    = 0;
    fe_pulses    = 0;
    stray_pulses = 0;
    last_rdr     = 8'h00;
    forever begin
      @(negedge clk);
      if (rx.setrdrf === 1'b1) begin
        rdrf_pulses++;
        last_rdr = rx.rdr;
        if (rx.setoe === 1'b1) oe_pulses++;
        if (rx.setfe === 1'b1) fe_pulses++;
      end else if (rx.setoe === 1'b1 || rx.setfe === 1'b1) begin
        stray_pulses++;
      end
    end
  end

  task automatic send_bit(input logic b, input int clks);
    rx.rxd = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input int clks);
    send_bit(1'b0, clks);
    for (int i = 0; i < 8; i++) send_bit(data[i], clks);
    send_bit(stop, clks);
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    rx.rxd  = 1'b1;
    rx.rdrf = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (rx.rdr !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_rdr: got %h expected %h", rx.rdr, 8'h00);
    end
    vectors++;
    if (rx.setrdrf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_setrdrf: got %b expected 0", rx.setrdrf);
    end
    vectors++;
    if (rx.setoe !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_setoe: got %b expected 0", rx.setoe);
    end
    vectors++;
    if (rx.setfe !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_setfe: got %b expected 0", rx.setfe);
    end
    vectors++;
    if (dut.state !== RX_IDLE) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %b expected %b", dut.state, RX_IDLE);
    end
    rst = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_basic_frame;
    int p0, o0, f0;
    p0 = rdrf_pulses; o0 = oe_pulses; f0 = fe_pulses;
    send_frame(8'h55, 1'b1, BIT_CLKS);
    send_bit(1'b1, 2 * BIT_CLKS);
    vectors++;
    if (rx.rdr !== 8'h55) begin
      miscompares++;
      $display("[TB] FAIL basic_rdr: got %h expected %h", rx.rdr, 8'h55);
    end
    vectors++;
    if (last_rdr !== 8'h55) begin
      miscompares++;
      $display("[TB] FAIL basic_rdr_at_pulse: got %h expected %h", last_rdr, 8'h55);
    end
    vectors++;
    if (rdrf_pulses - p0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL basic_setrdrf_count: got %0d expected 1", rdrf_pulses - p0);
    end
    vectors++;
    if ((oe_pulses - o0) + (fe_pulses - f0) !== 0) begin
      miscompares++;
      $display("[TB] FAIL basic_oe_fe: got %0d expected 0", (oe_pulses - o0) + (fe_pulses - f0));
    end
    vectors++;
    if (dut.state !== RX_IDLE) begin
      miscompares++;
      $display("[TB] FAIL basic_state: got %b expected %b", dut.state, RX_IDLE);
    end
  endtask

  task automatic test_glitch;
    int p0;
    p0 = rdrf_pulses;
    send_bit(1'b0, 32);
    send_bit(1'b1, 2 * BIT_CLKS);
    vectors++;
    if (rdrf_pulses - p0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL glitch_pulses: got %0d expected 0", rdrf_pulses - p0);
    end
    vectors++;
    if (rx.rdr !== 8'h55) begin
      miscompares++;
      $display("[TB] FAIL glitch_rdr: got %h expected %h", rx.rdr, 8'h55);
    end
    vectors++;
    if (dut.state !== RX_IDLE) begin
      miscompares++;
      $display("[TB] FAIL glitch_state: got %b expected %b", dut.state, RX_IDLE);
    end
  endtask

  task automatic test_break;
    int p0, f0, o0;
    p0 = rdrf_pulses; f0 = fe_pulses; o0 = oe_pulses;
    send_frame(8'hA3, 1'b0, BIT_CLKS);
    send_bit(1'b0, 20 * 16);
    vectors++;
    if (dut.state !== RX_BREAK) begin
      miscompares++;
      $display("[TB] FAIL break_state_low: got %b expected %b", dut.state, RX_BREAK);
    end
    vectors++;
    if (rx.rdr !== 8'hA3) begin
      miscompares++;
      $display("[TB] FAIL break_rdr: got %h expected %h", rx.rdr, 8'hA3);
    end
    vectors++;
    if (fe_pulses - f0 !== 1 || oe_pulses - o0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL break_fe: got fe=%0d oe=%0d expected fe=1 oe=0", fe_pulses - f0, oe_pulses - o0);
    end
    send_bit(1'b1, 2 * BIT_CLKS);
    vectors++;
    if (dut.state !== RX_IDLE) begin
      miscompares++;
      $display("[TB] FAIL break_state_release: got %b expected %b", dut.state, RX_IDLE);
    end
    vectors++;
    if (rdrf_pulses - p0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL break_frame_count: got %0d expected 1", rdrf_pulses - p0);
    end
  endtask

  task automatic test_back_to_back;
    int p0, o0;
    p0 = rdrf_pulses; o0 = oe_pulses;
    send_frame(8'h0F, 1'b1, BIT_CLKS);
    vectors++;
    if (last_rdr !== 8'h0F || oe_pulses - o0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got rdr=%h oe=%0d expected rdr=0f oe=0", last_rdr, oe_pulses - o0);
    end
    rx.rdrf = 1'b1;
    send_frame(8'hF0, 1'b1, BIT_CLKS);
    send_bit(1'b1, 2 * BIT_CLKS);
    rx.rdrf = 1'b0;
    vectors++;
    if (last_rdr !== 8'hF0) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_rdr: got %h expected %h", last_rdr, 8'hF0);
    end
    vectors++;
    if (rdrf_pulses - p0 !== 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_setrdrf_count: got %0d expected 2", rdrf_pulses - p0);
    end
    vectors++;
    if (oe_pulses - o0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL b2b_setoe_count: got %0d expected 1", oe_pulses - o0);
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] partial;
    int p0;
    partial = 8'h3C;
    p0 = rdrf_pulses;
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) send_bit(partial[i], BIT_CLKS);
    send_bit(partial[4], 64);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (rx.rdr !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL midrst_rdr: got %h expected %h", rx.rdr, 8'h00);
    end
    vectors++;
    if (dut.state !== RX_IDLE) begin
      miscompares++;
      $display("[TB] FAIL midrst_state: got %b expected %b", dut.state, RX_IDLE);
    end
    rx.rxd = 1'b1;
    rst = 1'b0;
    send_bit(1'b1, 3 * BIT_CLKS);
    vectors++;
    if (rdrf_pulses - p0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL midrst_no_pulse: got %0d expected 0", rdrf_pulses - p0);
    end
    send_frame(8'hC3, 1'b1, BIT_CLKS);
    send_bit(1'b1, 2 * BIT_CLKS);
    vectors++;
    if (rx.rdr !== 8'hC3 || rdrf_pulses - p0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL midrst_next_frame: got rdr=%h pulses=%0d expected rdr=c3 pulses=1", rx.rdr, rdrf_pulses - p0);
    end
  endtask

  task automatic test_baud_sweep;
    int lens[2];
    int p0, f0;
    lens[0] = 124;
    lens[1] = 132;
    for (int k = 0; k < 2; k++) begin
      p0 = rdrf_pulses; f0 = fe_pulses;
      send_frame(8'h96, 1'b1, lens[k]);
      send_bit(1'b1, 2 * BIT_CLKS);
      vectors++;
      if (last_rdr !== 8'h96 || rdrf_pulses - p0 !== 1) begin
        miscompares++;
        $display("[TB] FAIL sweep_rdr_len%0d: got rdr=%h pulses=%0d expected rdr=96 pulses=1", lens[k], last_rdr, rdrf_pulses - p0);
      end
      vectors++;
      if (fe_pulses - f0 !== 0) begin
        miscompares++;
        $display("[TB] FAIL sweep_fe_len%0d: got %0d expected 0", lens[k], fe_pulses - f0);
      end
    end
  endtask

  task automatic test_stray_pulses;
    vectors++;
    if (stray_pulses !== 0) begin
      miscompares++;
      $display("[TB] FAIL stray_oe_fe: got %0d expected 0", stray_pulses);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    rx.rxd      = 1'b1;
    rx.rdrf     = 1'b0;
    test_reset();
    test_basic_frame();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_midframe();
    test_baud_sweep();
    test_stray_pulses();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART: deserialises the asynchronous `rxd` line into bytes using an 8× oversampling baud tick. It validates the start bit, samples each bit at mid-cell, and checks the stop bit. Each received byte goes to the receive data register (`rdr`), along with single-cycle set pulses for the receive-full, overrun and framing-error status flags. It sits beside the transmitter and shares the baud generator and the status register.

## Interface
Parameters:
- none (frame fixed: 1 start, 8 data LSB-first, 1 stop, no parity; oversampling fixed at 8)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `bclkx8`  in  1  baud×8 clock from baud generator, slow relative to `clk`, rising edge detected internally
- `rxd`  in  1  serial line, asynchronous, idle high
- `rdrf`  in  1  current receive-data-register-full flag from status register
- `rdr`  out  8  last received byte
- `setrdrf`  out  1  one-cycle pulse: new byte in `rdr`
- `setoe`  out  1  one-cycle pulse: byte arrived while `rdrf`=1 (overrun)
- `setfe`  out  1  one-cycle pulse: stop bit sampled 0 (framing error)

## Operation
- `rxd` passes through a 2-flop synchroniser to give `rxd_s`.
- `bclkx8` is registered to give `bclkd`; `tick = bclkx8 & ~bclkd`. All FSM actions occur only on `tick` cycles.
- Internal state:
  - `rsr[7:0]` shift register
  - `ct1[2:0]` oversample counter
  - `ct2[3:0]` bit counter
- State encoding: idle=2'b00, start_detect=2'b01, recv_data=2'b11, break_wait=2'b10.
- idle: on tick with `rxd_s`=0 → start_detect, ct1=0.
- start_detect: on tick:
  - `rxd_s`=1 → idle, ct1 cleared (glitch rejected).
  - else if ct1==3 → recv_data, ct1 cleared. Start is confirmed after 1+4 consecutive low samples.
  - else ct1++.
- recv_data: on every tick ct1++ (wraps 7→0). On a tick with ct1==7 (mid-cell):
  - ct2<8: `rsr <= {rxd_s, rsr[7:1]}`, ct2++.
  - ct2==8 (stop bit):
    - `rdr <= rsr`; pulse `setrdrf`.
    - `setoe` = `rdrf`; `setfe` = ~`rxd_s`.
    - ct1 and ct2 cleared.
    - Next state: break_wait if `rxd_s`=0, else idle.
- break_wait: on tick with `rxd_s`=1 → idle. A line held low, such as a break, yields exactly one frame with FE, then nothing.
- A byte with a framing error is still loaded into `rdr`, and `setrdrf` still pulses.
- Overrun does not block the load: `rdr` is overwritten and `setoe` flags the loss.

## Timing
- Reset values:
  - outputs: `rdr`=8'h00, `setrdrf`=`setoe`=`setfe`=0
  - state idle, `rsr`=0, ct1=0, ct2=0
  - synchroniser flops=1, `bclkd`=0
- `setrdrf`, `setoe` and `setfe` are registered and high for exactly one `clk` cycle. That cycle is the one after the stop-sample tick, the same cycle `rdr` first shows the new byte.
- `rxd` to FSM latency: 2 `clk` (synchroniser).
- Data-bit sample points are 8 ticks apart, first at tick 8 after start confirmation.
- `rdrf` is sampled on the stop-sample tick cycle only.
- Reset asserted mid-frame: everything returns to reset values immediately; no pulse is emitted; a partial byte is discarded.
- `rdr` holds its value between frames and is not cleared by `rdrf`.

## Structure
- Shared package/include `uart_defs`:
  - RX state encodings
  - frame length constant (8 data bits)
  - oversample constant (8)
  - mid-cell sample index (7)
- Sub-module `uart_sync2`: 2-flop synchroniser with reset value 1, reusable for other async inputs.
- Tick edge detect, FSM and datapath stay in `uart_rx`.

## Test plan
- Frame 0x55, stop=1, `rdrf`=0 → `rdr`=8'h55, one `setrdrf` pulse, `setoe`=`setfe`=0, FSM back in idle.
- `rxd` low for 2 ticks then high → no pulses, `rdr` unchanged, FSM idle.
- Frame 0xA3 with stop bit 0, line then held low 20 ticks → `rdr`=8'hA3, `setrdrf`+`setfe` pulse once, FSM in break_wait until `rxd` high, no second frame.
- Back-to-back frames 0x0F then 0xF0, `rdrf` raised after the first → second frame gives `rdr`=8'hF0, `setrdrf` and `setoe` pulse together.
- `rst` asserted at data bit 4 of frame 0x3C, released, then frame 0xC3 sent → no pulse for the aborted frame, `rdr`=8'hC3 after the second.
- Bit-cell sweep ±3% baud error on 0x96 → `rdr`=8'h96, no FE.
